// File: rtl/nts_api_router.sv
`default_nettype none
// ============================================================================
// Module  : nts_api_router
// Brief   : Routes one external register bus onto SLAVES internal register
//           ports with per-slave ready handshake, bounded timeout and error
//           response for unmapped or timed-out accesses.
// Rev     : 1.0 - initial release
// ============================================================================
module nts_api_router #(
    parameter int                    SLAVES         = 8,
    parameter int                    EXT_ADDR_WIDTH = 12,
    parameter int                    INT_ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT        = 16,
    parameter logic [DATA_WIDTH-1:0] ERROR_WORD     = 32'hDEAD_BEEF
) (
    input  logic                         i_clk,
    input  logic                         i_areset_n,
    input  logic                         i_external_api_cs,
    input  logic                         i_external_api_we,
    input  logic [EXT_ADDR_WIDTH-1:0]    i_external_api_address,
    input  logic [DATA_WIDTH-1:0]        i_external_api_write_data,
    output logic [DATA_WIDTH-1:0]        o_external_api_read_data,
    output logic                         o_external_api_read_data_valid,
    output logic                         o_busy,
    output logic                         o_error,
    output logic                         o_overrun,
    output logic [SLAVES-1:0]            o_internal_api_cs,
    output logic                         o_internal_api_we,
    output logic [INT_ADDR_WIDTH-1:0]    o_internal_api_address,
    output logic [DATA_WIDTH-1:0]        o_internal_api_write_data,
    input  logic [SLAVES-1:0]            i_internal_api_ready,
    input  logic [SLAVES*DATA_WIDTH-1:0] i_internal_api_read_data
);

    localparam int IDX_W = EXT_ADDR_WIDTH - INT_ADDR_WIDTH;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0]   C_SLAVES   = (IDX_W + 1)'(SLAVES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [SLAVES-1:0]         r_cs;
    logic                      r_int_we;
    logic [INT_ADDR_WIDTH-1:0] r_int_addr;
    logic [DATA_WIDTH-1:0]     r_int_wdata;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic                      r_valid;
    logic                      r_busy;
    logic                      r_error;
    logic                      r_overrun;

    logic [IDX_W-1:0]          w_ext_idx;
    logic                      w_accept;
    logic                      w_unmapped;
    logic                      w_sel_ready;
    logic [SLAVES-1:0]         w_onehot;
    logic [DATA_WIDTH-1:0]     w_sel_data;

    assign w_ext_idx   = i_external_api_address[EXT_ADDR_WIDTH-1:INT_ADDR_WIDTH];
    assign w_accept    = i_external_api_cs && (r_state != ST_ACCESS);
    // Extra MSB keeps the compare correct when SLAVES fills the whole index space
    assign w_unmapped  = ({1'b0, w_ext_idx} >= C_SLAVES);
    // r_cs is one-hot during ACCESS, so masking selects exactly one ready
    assign w_sel_ready = |(r_cs & i_internal_api_ready);

    always_comb begin
        w_onehot   = '0;
        w_sel_data = '0;
        for (int k = 0; k < SLAVES; k++) begin
            w_onehot[k] = (w_ext_idx == IDX_W'(k));
            w_sel_data  = w_sel_data |
                          ({DATA_WIDTH{r_cs[k]}} & i_internal_api_read_data[k*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cs        <= '0;
            r_int_we    <= 1'b0;
            r_int_addr  <= '0;
            r_int_wdata <= '0;
            r_rdata     <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
            r_overrun <= 1'b0;
            case (r_state)
                ST_ACCESS: begin
                    r_overrun <= i_external_api_cs;
                    if (w_sel_ready || (r_cnt == C_CNT_LAST)) begin
                        r_state     <= ST_DONE;
                        r_valid     <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cs        <= '0;
                        r_int_we    <= 1'b0;
                        r_int_addr  <= '0;
                        r_int_wdata <= '0;
                        // A ready on the final counted cycle still wins over timeout
                        if (w_sel_ready) begin
                            r_rdata <= r_int_we ? '0 : w_sel_data;
                        end else begin
                            r_rdata <= ERROR_WORD;
                            r_error <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        if (w_unmapped) begin
                            r_state <= ST_DONE;
                            r_rdata <= ERROR_WORD;
                            r_valid <= 1'b1;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state     <= ST_ACCESS;
                            r_cnt       <= '0;
                            r_cs        <= w_onehot;
                            r_int_we    <= i_external_api_we;
                            r_int_addr  <= i_external_api_address[INT_ADDR_WIDTH-1:0];
                            r_int_wdata <= i_external_api_write_data;
                            r_busy      <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_external_api_read_data       = r_rdata;
    assign o_external_api_read_data_valid = r_valid;
    assign o_busy                         = r_busy;
    assign o_error                        = r_error;
    assign o_overrun                      = r_overrun;
    assign o_internal_api_cs              = r_cs;
    assign o_internal_api_we              = r_int_we;
    assign o_internal_api_address         = r_int_addr;
    assign o_internal_api_write_data      = r_int_wdata;

endmodule
`default_nettype wire

// File: tb/tb_nts_api_router.sv
`default_nettype none
// ============================================================================
// Module  : tb_nts_api_router
// Brief   : Self-checking bench for nts_api_router (vector table + sequences).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_nts_api_router;

    localparam logic [31:0] C_ERR = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        ext_cs, ext_cs6, ext_we;
    logic [11:0] ext_addr;
    logic [31:0] ext_wdata;

    logic [31:0]  rdata, int_wdata;
    logic         valid, busy, error, overrun, int_we;
    logic [7:0]   int_cs, int_addr, int_ready;
    logic [255:0] int_rdata;

    logic [31:0]  rdata6, int_wdata6;
    logic         valid6, busy6, error6, overrun6, int_we6;
    logic [5:0]   int_cs6;
    logic [7:0]   int_addr6;
    logic [5:0]   int_ready6;
    logic [191:0] int_rdata6;
    assign int_ready6 = '0;
    assign int_rdata6 = '0;

    nts_api_router #(.SLAVES(8), .TIMEOUT(16)) u_dut (
        .i_clk                          (clk),
        .i_areset_n                     (rst_n),
        .i_external_api_cs              (ext_cs),
        .i_external_api_we              (ext_we),
        .i_external_api_address         (ext_addr),
        .i_external_api_write_data      (ext_wdata),
        .o_external_api_read_data       (rdata),
        .o_external_api_read_data_valid (valid),
        .o_busy                         (busy),
        .o_error                        (error),
        .o_overrun                      (overrun),
        .o_internal_api_cs              (int_cs),
        .o_internal_api_we              (int_we),
        .o_internal_api_address         (int_addr),
        .o_internal_api_write_data      (int_wdata),
        .i_internal_api_ready           (int_ready),
        .i_internal_api_read_data       (int_rdata)
    );

    nts_api_router #(.SLAVES(6), .TIMEOUT(16)) u_dut6 (
        .i_clk                          (clk),
        .i_areset_n                     (rst_n),
        .i_external_api_cs              (ext_cs6),
        .i_external_api_we              (ext_we),
        .i_external_api_address         (ext_addr),
        .i_external_api_write_data      (ext_wdata),
        .o_external_api_read_data       (rdata6),
        .o_external_api_read_data_valid (valid6),
        .o_busy                         (busy6),
        .o_error                        (error6),
        .o_overrun                      (overrun6),
        .o_internal_api_cs              (int_cs6),
        .o_internal_api_we              (int_we6),
        .o_internal_api_address         (int_addr6),
        .o_internal_api_write_data      (int_wdata6),
        .i_internal_api_ready           (int_ready6),
        .i_internal_api_read_data       (int_rdata6)
    );

    // Slave models: ready after slave_wait[k] cycles of cs (-1 = never); slave 2 is a RAM
    int          slave_wait [8];
    logic [31:0] rd_word    [8];
    logic [7:0]  wcnt       [8];
    logic [7:0]  force_rdy;
    logic [31:0] mem        [256];

    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) wcnt[k] <= int_cs[k] ? wcnt[k] + 8'd1 : 8'd0;
        if (int_cs[2] && int_we) mem[int_addr] <= int_wdata;
    end

    always_comb begin
        int_ready = '0;
        int_rdata = '0;
        for (int k = 0; k < 8; k++) begin
            int_ready[k] = force_rdy[k] |
                           (int_cs[k] && (slave_wait[k] >= 0) && (int'(wcnt[k]) >= slave_wait[k]));
            int_rdata[k*32 +: 32] = (k == 2) ? mem[int_addr] : rd_word[k];
        end
    end

    logic cs6_seen = 1'b0;
    always @(negedge clk) if (int_cs6 != '0) cs6_seen <= 1'b1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        int          wait_n;
        logic [31:0] sdata;
        logic [7:0]  force_rdy;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [7:0]  exp_cs;
        int          exp_cs_cycles;
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input vec_t v);
        int          idx;
        int          lat;
        int          cs_cycles;
        int          bad;
        logic [31:0] got_rdata;
        logic        got_err;
        logic [49:0] idle_p;
        lat = -1; cs_cycles = 0; bad = 0;
        got_rdata = '0; got_err = 1'b0; idle_p = '0;
        idx = int'(v.addr[11:8]);
        if (idx < 8) begin
            slave_wait[idx] = v.wait_n;
            rd_word[idx]    = v.sdata;
        end
        force_rdy = v.force_rdy;
        @(posedge clk); #1;
        ext_cs = 1'b1; ext_we = v.we; ext_addr = v.addr; ext_wdata = v.wdata;
        @(posedge clk); #1;
        ext_cs = 1'b0; ext_we = ~v.we; ext_addr = ~v.addr; ext_wdata = ~v.wdata;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (int_cs != '0) begin
                cs_cycles++;
                if (int_cs !== v.exp_cs || int_addr !== v.addr[7:0] || int_we !== v.we ||
                    int_wdata !== v.wdata || busy !== 1'b1)
                    bad++;
            end
            if (valid === 1'b1) begin
                lat       = c;
                got_rdata = rdata;
                got_err   = error;
                idle_p    = {int_cs, int_we, int_addr, int_wdata, busy};
                break;
            end
        end
        chk({v.name, "_latency"},   64'(lat),       64'(v.exp_lat));
        chk({v.name, "_rdata"},     64'(got_rdata), 64'(v.exp_rdata));
        chk({v.name, "_error"},     64'(got_err),   64'(v.exp_err));
        chk({v.name, "_cs_cycles"}, 64'(cs_cycles), 64'(v.exp_cs_cycles));
        chk({v.name, "_access"},    64'(bad),       64'd0);
        chk({v.name, "_idle_ports"}, 64'(idle_p),   64'd0);
        @(negedge clk);
        chk({v.name, "_after"}, 64'({valid, error, rdata}), 64'({1'b0, 1'b0, v.exp_rdata}));
        force_rdy = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_d;
        int          wbad;

        vecs[0] = '{"rd_s0_w0",      1'b0, 12'h005, 32'h0,        0, 32'h0A00_0005, 8'h00, 32'h0A00_0005, 1'b0,  2, 8'h01,  1};
        vecs[1] = '{"rd_s5_w3",      1'b0, 12'h5A0, 32'h0,        3, 32'h1234_5678, 8'h00, 32'h1234_5678, 1'b0,  5, 8'h20,  4};
        vecs[2] = '{"wr_s5_w3",      1'b1, 12'h5A1, 32'h0000_CAFE, 3, 32'h1234_5678, 8'h00, 32'h0,         1'b0,  5, 8'h20,  4};
        vecs[3] = '{"rd_s3_timeout", 1'b0, 12'h3FF, 32'h0,       -1, 32'h3333_3333, 8'hF7, C_ERR,         1'b1, 17, 8'h08, 16};
        vecs[4] = '{"rd_unmap_9",    1'b0, 12'h900, 32'h0,        0, 32'h0,         8'h00, C_ERR,         1'b1,  1, 8'h00,  0};
        vecs[5] = '{"rd_s7_w1",      1'b0, 12'h742, 32'h0,        1, 32'h7777_0042, 8'h00, 32'h7777_0042, 1'b0,  3, 8'h80,  2};
        vecs[6] = '{"wr_s0_w0",      1'b1, 12'h0FF, 32'h5555_AAAA, 0, 32'h0A00_0005, 8'h00, 32'h0,         1'b0,  2, 8'h01,  1};
        vecs[7] = '{"rd_unmap_15",   1'b0, 12'hFFF, 32'h0,        0, 32'h0,         8'h00, C_ERR,         1'b1,  1, 8'h00,  0};
        vecs[8] = '{"rd_s6_w15",     1'b0, 12'h6AB, 32'h0,       15, 32'h6666_00AB, 8'h00, 32'h6666_00AB, 1'b0, 17, 8'h40, 16};

        for (int k = 0; k < 8; k++) begin
            slave_wait[k] = -1;
            rd_word[k]    = '0;
        end
        force_rdy = '0;
        ext_cs = 1'b0; ext_cs6 = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_ext", 64'({rdata, valid, busy, error, overrun}), 64'd0);
        chk("reset_int", 64'({int_cs, int_we, int_addr, int_wdata}), 64'd0);
        chk("reset_u6",  64'({rdata6, valid6, busy6, error6, int_cs6}), 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Overrun: request pulsed mid-access is dropped, original response intact
        slave_wait[5] = 3; rd_word[5] = 32'h1234_5678;
        @(posedge clk); #1;
        ext_cs = 1'b1; ext_we = 1'b0; ext_addr = 12'h5A0;
        @(posedge clk); #1; ext_cs = 1'b0;
        @(negedge clk);
        chk("ovr_t1", 64'(overrun), 64'd0);
        @(posedge clk); #1;
        ext_cs = 1'b1; ext_addr = 12'h005;
        @(posedge clk); #1; ext_cs = 1'b0;
        @(negedge clk);
        chk("ovr_t3", 64'({overrun, busy, int_cs}), 64'({1'b1, 1'b1, 8'h20}));
        @(negedge clk);
        chk("ovr_t4", 64'({overrun, int_cs}), 64'({1'b0, 8'h20}));
        @(negedge clk);
        chk("ovr_resp", 64'({valid, error, rdata}), 64'({1'b1, 1'b0, 32'h1234_5678}));
        @(negedge clk);
        chk("ovr_dropped", 64'({valid, int_cs, overrun}), 64'd0);

        // Back-to-back writes then reads against the slave 2 RAM
        slave_wait[2] = 0;
        wbad = 0;
        for (int i = 0; i < 256; i++) begin
            ext_cs = 1'b1; ext_we = 1'b1;
            ext_addr = 12'h200 + 12'(i);
            ext_wdata = 32'h7FFF_FFFF + 32'(17 * i);
            @(posedge clk); #1; ext_cs = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            if (valid !== 1'b1 || rdata !== 32'h0) wbad++;
        end
        chk("b2b_writes", 64'(wbad), 64'd0);
        for (int i = 0; i < 256; i++) begin
            ext_cs = 1'b1; ext_we = 1'b0;
            ext_addr = 12'h200 + 12'(i);
            ext_wdata = '0;
            exp_d = 32'h7FFF_FFFF + 32'(17 * i);
            @(posedge clk); #1; ext_cs = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            chk("b2b_read", 64'({valid, rdata}), 64'({1'b1, exp_d}));
        end
        @(negedge clk);
        chk("b2b_idle", 64'({valid, busy, int_cs}), 64'd0);

        // SLAVES=6 instance: index 7 is unmapped
        ext_cs6 = 1'b1; ext_we = 1'b0; ext_addr = 12'h700;
        @(posedge clk); #1; ext_cs6 = 1'b0;
        @(negedge clk);
        chk("u6_unmapped", 64'({valid6, error6, busy6, rdata6}), 64'({1'b1, 1'b1, 1'b0, C_ERR}));
        @(negedge clk);
        chk("u6_after", 64'({valid6, error6, rdata6}), 64'({1'b0, 1'b0, C_ERR}));

        // Asynchronous reset mid-access
        slave_wait[5] = 3; rd_word[5] = 32'hABCD_0001;
        @(posedge clk); #1;
        ext_cs = 1'b1; ext_we = 1'b0; ext_addr = 12'h5A0;
        @(posedge clk); #1; ext_cs = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("arst_pre", 64'({int_cs, busy}), 64'({8'h20, 1'b1}));
        #1 rst_n = 1'b0;
        #1;
        chk("arst_ports", 64'({int_cs, busy, valid, error, overrun}), 64'd0);
        chk("arst_rdata", 64'(rdata), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0]);

        chk("u6_cs_never", 64'(cs6_seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nts_api_router.md
Name: nts_api_router

Overview:
- Parametrised successor to the fixed 7-port API decoder.
- Decodes one external 32-bit register bus onto SLAVES internal register ports.
- Adds a per-slave ready handshake, so slaves can insert wait states, plus a bounded timeout.
- Unmapped or timed-out accesses return an error word. Accesses arriving while busy are flagged as overruns.

Parameters:
SLAVES, 8, number of internal slave ports (1..2**(EXT_ADDR_WIDTH-INT_ADDR_WIDTH))
EXT_ADDR_WIDTH, 12, external address width
INT_ADDR_WIDTH, 8, internal address width; slave index = ext_addr[EXT_ADDR_WIDTH-1:INT_ADDR_WIDTH]
DATA_WIDTH, 32, data width
TIMEOUT, 16, max cycles cs is held waiting for ready (>=1)
ERROR_WORD, 32'hDEAD_BEEF, read data returned on unmapped/timeout

Ports:
i_clk  in  1  clock
i_areset_n  in  1  asynchronous reset, active low
i_external_api_cs  in  1  access request, sampled each rising edge
i_external_api_we  in  1  1=write, 0=read
i_external_api_address  in  EXT_ADDR_WIDTH  address
i_external_api_write_data  in  DATA_WIDTH  write data
o_external_api_read_data  out  DATA_WIDTH  response data
o_external_api_read_data_valid  out  1  one-cycle response strobe (reads and writes)
o_busy  out  1  transaction in progress
o_error  out  1  one-cycle strobe coincident with valid on unmapped/timeout
o_overrun  out  1  one-cycle strobe: cs dropped because busy
o_internal_api_cs  out  SLAVES  one-hot slave select
o_internal_api_we  out  1  write enable
o_internal_api_address  out  INT_ADDR_WIDTH  internal address
o_internal_api_write_data  out  DATA_WIDTH  write data
i_internal_api_ready  in  SLAVES  per-slave ready (read data valid / write accepted)
i_internal_api_read_data  in  SLAVES*DATA_WIDTH  flattened read data; slave k at [k*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset (async, i_areset_n=0):
  - State IDLE; timeout counter 0.
  - All outputs 0, including read_data.
  - Any in-flight access is abandoned and cs drops immediately.
- FSM states are IDLE, ACCESS and DONE. A request is accepted in IDLE or DONE when i_external_api_cs=1.
- On accept:
  - Latch we, address and write data.
  - idx = upper address bits.
  - If idx >= SLAVES: go to DONE with read_data=ERROR_WORD, error=1.
  - Otherwise: go to ACCESS and clear the counter.
- ACCESS:
  - o_internal_api_cs[idx]=1 (exactly one bit). o_busy=1.
  - we, address[INT_ADDR_WIDTH-1:0] and write data are held stable.
  - If i_internal_api_ready[idx]=1 at the edge: go to DONE.
    - Read: read_data = slave idx data.
    - Write: read_data = 0.
  - Ready of non-selected slaves is ignored.
  - Otherwise the counter increments. If the counter equals TIMEOUT-1 with ready low: go to DONE with read_data=ERROR_WORD, error=1. cs is therefore asserted for exactly TIMEOUT cycles.
- DONE: valid=1 and busy=0 for one cycle. Then IDLE, or ACCESS if a new request is accepted that cycle (back-to-back).
- read_data holds its value until the next response is loaded. It does not clear on valid falling.
- Internal we/address/write_data are 0 whenever not in ACCESS. o_internal_api_cs is all-zero outside ACCESS.
- Overrun: i_external_api_cs=1 while in ACCESS → request dropped, o_overrun=1 next cycle, transaction unaffected.
- Latency:
  - Zero-wait slave (ready combinational high): accept edge T0, ACCESS in T1, valid in T2.
  - N wait states: valid in T2+N.
  - Unmapped: valid in T1.

Test Plan:
- Read 0x005 with slave 0 ready tied high and returning 0x0A00_0005 → cs=8'b0000_0001 for 1 cycle, internal addr 0x05, valid 2 cycles after accept with data 0x0A00_0005, error=0, then valid=0.
- Read 0x5A0 with slave 5 ready after 3 wait cycles, data 0x1234_5678 → cs[5] held 4 cycles, valid at T5 with data 0x1234_5678. Write 0x5A1 data 0xCAFE → slave sees we=1 and data 0xCAFE while cs, response data 0.
- Read 0x3FF with slave 3 never ready, TIMEOUT=16 → cs[3] high exactly 16 cycles, then valid=1, error=1, data 0xDEAD_BEEF; all cs=0 afterwards.
- SLAVES=6, read 0x700 → no cs ever asserted, valid next cycle, error=1, data 0xDEAD_BEEF.
- cs pulsed during a 3-wait access → o_overrun one cycle, original response unchanged. Then run 256 back-to-back writes/reads to a slave memory model at 0x200+i with value 0x7FFF_FFFF+17*i → every readback matches.
- Assert i_areset_n=0 mid-ACCESS → cs, busy and valid go 0 asynchronously. After release, a read of 0x005 completes normally.
